fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage placed directly upstream of the single-cycle core's decode/execute path, between a variable-latency instruction memory and the consumer of `inst`/`pc`. It generates sequential fetch addresses, performs a req/ack transaction per word with the memory, and buffers fetched words with their PCs in a small FIFO. The consumer drains the FIFO with a valid/ready handshake and redirects fetch on taken branches and jumps, which flushes all buffered and in-flight words.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  memory request; held high until `imem_ack`.
- `imem_addr`  out  `ADDR_LEN`  request address; stable while `imem_req` is high.
- `imem_ack`  in  1  one-cycle pulse ending the transaction; `imem_rdata` valid in that cycle.
- `imem_rdata`  in  `DATA_LEN`  fetched word.
- `redirect`  in  1  one-cycle pulse: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  `ADDR_LEN`  new fetch address; word-aligned.
- `inst_valid`  out  1  FIFO head valid (count ≠ 0).
- `inst_ready`  in  1  consumer accepts head when `inst_valid` is high.
- `inst`  out  `DATA_LEN`  head instruction.
- `inst_pc`  out  `ADDR_LEN`  PC of head instruction.

## Operation
- Registers: `fetch_pc` (next address to issue), `req_addr` (drives `imem_addr`), FIFO storage, read/write pointers, count (0..DEPTH), 3-state FSM.
- IDLE: if count < DEPTH and no `redirect` → REQ, `req_addr` ← `fetch_pc`. Otherwise stay.
- REQ: `imem_req`=1. On `imem_ack` without `redirect`: push {`req_addr`, `imem_rdata`}, `fetch_pc` ← `fetch_pc`+4, → IDLE. On `redirect` without ack → DRAIN. On `redirect` with ack → data discarded, → IDLE.
- DRAIN: `imem_req`=1, `imem_addr` unchanged (old request); on `imem_ack` discard data → IDLE. A further `redirect` in DRAIN only updates `fetch_pc`.
- Redirect (any state): `fetch_pc` ← `redirect_pc`, FIFO count ← 0, pointers reset. A pop in the same cycle counts as consumed; result is still empty.
- Pop: `inst_valid && inst_ready` advances read pointer. Push and pop in the same cycle: count unchanged.
- Overflow impossible: at most one outstanding request, issued only when count < DEPTH. Pointers wrap modulo DEPTH; `fetch_pc` wraps modulo 2^32.
- `inst`/`inst_pc` are read combinationally from registered storage at the read pointer.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fetch_pc`=`RESET_PC`, count=0, FSM=IDLE.
- First clock edge after reset release: IDLE→REQ; `imem_req` high the following cycle.
- Ack in cycle N → `inst_valid` high in cycle N+1 (registered push).
- Base throughput: one word per 2 cycles with single-cycle-ack memory (IDLE bubble).
- `redirect` in cycle N → `inst_valid`=0 in cycle N+1; first new request issued by cycle N+2 from IDLE, or 1 cycle after the draining ack.
- Reset asserted mid-transaction: all state cleared immediately; the outstanding request is abandoned (memory is reset together with the core).

## Configuration
- `FETCH_BACK2BACK_EN` defined: on ack in REQ without `redirect`, if count after this cycle's push/pop is < DEPTH, stay in REQ with `req_addr` ← `fetch_pc`+4; `imem_req` stays high and a new transaction starts the cycle after the ack. Throughput one word per cycle.
- Undefined: REQ always returns to IDLE after ack (one-cycle bubble as above).

## Test plan
- Reset, memory acks one cycle after req, `inst_ready`=1 → `inst_pc` sequence 0x0,0x4,0x8…; `inst` matches memory image; `imem_req` never high during rst.
- `inst_ready`=0 → exactly DEPTH=4 acks accepted, then `imem_req` stays low; release ready → entries drained in order, fetch resumes at 0x10.
- Redirect to 0x100 while FIFO holds 3 entries and no request outstanding → `inst_valid`=0 next cycle; next `imem_addr`=0x100.
- Redirect to 0x200 during REQ with ack 3 cycles later → `imem_addr` held at old value until ack, data discarded, next request at 0x200; no stale word reaches `inst`.
- Simultaneous pop and push at count=DEPTH−1 → count unchanged, order preserved; redirect coinciding with ack → word dropped, next request at `redirect_pc`.
- With `FETCH_BACK2BACK_EN`, single-cycle ack, ready=1 → one `inst_valid` beat per cycle after fill; without it, every other cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential req/ack fetch into a small PC-tagged FIFO, flushed on redirect.
// Optional FETCH_BACK2BACK_EN keeps the request line busy across acks for one word per cycle.
module fetch_unit #(
    parameter int                  DEPTH    = 4,
    parameter int                  ADDR_LEN = 32,
    parameter int                  DATA_LEN = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [DATA_LEN-1:0] imem_rdata,
    input  logic                redirect,
    input  logic [ADDR_LEN-1:0] redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_LEN-1:0] inst,
    output logic [ADDR_LEN-1:0] inst_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t              state, state_next;
    logic [ADDR_LEN-1:0] fetch_pc, req_addr;
    logic [DATA_LEN-1:0] data_mem [DEPTH];
    logic [ADDR_LEN-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count, count_next;
    logic                issue, push, pop, chain;

    assign issue = (state == IDLE) && (count < FULL) && !redirect;
    assign push  = (state == REQ) && imem_ack && !redirect;
    assign pop   = (count != '0) && inst_ready;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

`ifdef FETCH_BACK2BACK_EN
    // Chain straight into the next word whenever the FIFO still has room after this cycle.
    assign chain = push && (count_next < FULL);
`else
    assign chain = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    state_next = chain ? REQ : IDLE;
                end else if (redirect) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state != IDLE);
        imem_addr = req_addr;
    end

    // req_addr only changes when a new transaction starts, so the address stays put through DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (push) begin
                fetch_pc <= fetch_pc + ADDR_LEN'(4);
            end
            if (issue) begin
                req_addr <= fetch_pc;
            end else if (chain) begin
                req_addr <= fetch_pc + ADDR_LEN'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= imem_rdata;
                pc_mem[wr_ptr]   <= req_addr;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

    assign inst_valid = (count != '0);
    assign inst       = data_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a vector table and a randomized run
// against a queue-based reference model. Throughput expectations follow FETCH_BACK2BACK_EN.
module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int tests = 0;
    int fails = 0;
    int lat_max = 0;
    bit mem_hold = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    typedef struct packed {
        logic [31:0]      start_pc;
        logic [3:0][31:0] exp_pc;
        logic [31:0]      exp_next;
    } vec_t;

    fetch_unit #(
        .DEPTH(DEPTH),
        .ADDR_LEN(32),
        .DATA_LEN(32),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory responds a random 0..lat_max cycles after the request rises; mem_hold stalls it.
    initial begin
        int wait_cnt;
        int cur_lat;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        wait_cnt   = 0;
        cur_lat    = 0;
        forever begin
            @(negedge clk);
            #1;
            imem_ack = 1'b0;
            if (rst || !imem_req) begin
                wait_cnt = 0;
                cur_lat  = $urandom_range(lat_max, 0);
            end else if (!mem_hold && wait_cnt >= cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
                cur_lat    = $urandom_range(lat_max, 0);
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] rpc, input logic rdy);
        redirect    = r;
        redirect_pc = rpc;
        inst_ready  = rdy;
    endtask

    // Called on a negedge; returns on the negedge where reset is released.
    task automatic doReset();
        applyStimulus(1'b0, 32'h0, 1'b0);
        mem_hold = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_addr", imem_addr, RESET_PC);
        checkOutput("rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst", inst, 32'd0);
        checkOutput("rst_pc", inst_pc, 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_req_hold", 32'(imem_req), 32'd0);
        end
        rst = 1'b0;
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(imem_req), 32'd1);
    endtask

    initial begin
        vec_t        vecs[5];
        entry_t      q[$];
        entry_t      e;
        logic [31:0] exp_pc;
        int          beats;
        int          acks;
        int          n;
        bit          m_busy;
        bit          m_stale;
        logic [31:0] m_addr;
        logic [31:0] m_npc;
        int          sz0;
        bit          r;
        bit          r_prev;

        vecs[0] = '{32'h0000_0000, {32'h0000_000C, 32'h0000_0008, 32'h0000_0004, 32'h0000_0000}, 32'h0000_0010};
        vecs[1] = '{32'h0000_0100, {32'h0000_010C, 32'h0000_0108, 32'h0000_0104, 32'h0000_0100}, 32'h0000_0110};
        vecs[2] = '{32'hFFFF_FFF8, {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8}, 32'h0000_0008};
        vecs[3] = '{32'h8000_0000, {32'h8000_000C, 32'h8000_0008, 32'h8000_0004, 32'h8000_0000}, 32'h8000_0010};
        vecs[4] = '{32'h1234_5670, {32'h1234_567C, 32'h1234_5678, 32'h1234_5674, 32'h1234_5670}, 32'h1234_5680};

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);

        // Sequential stream and throughput with a single-cycle-ack memory.
        doReset();
        lat_max = 0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        exp_pc = RESET_PC;
        beats  = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0) checkOutput("idle_after_rst", 32'(imem_req), 32'd0);
            if (c == 1) begin
                checkOutput("first_req", 32'(imem_req), 32'd1);
                checkOutput("first_addr", imem_addr, RESET_PC);
            end
            if (inst_valid) begin
                checkOutput("seq_pc", inst_pc, exp_pc);
                checkOutput("seq_inst", inst, mem_word(exp_pc));
                exp_pc += 32'd4;
                if (c >= 10 && c < 30) beats++;
            end
            @(negedge clk);
        end
`ifdef FETCH_BACK2BACK_EN
        checkOutput("throughput", beats, 32'd20);
`else
        checkOutput("throughput", beats, 32'd10);
`endif

        // Redirect with three words buffered.
        doReset();
        acks = 0;
        n = 0;
        while (acks < 3 && n < 40) begin
            @(negedge clk);
            #2;
            if (imem_ack) acks++;
            n++;
        end
        checkOutput("fill3_acks", acks, 32'd3);
        @(negedge clk);
        checkOutput("fill3_valid", 32'(inst_valid), 32'd1);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("redir_flush", 32'(inst_valid), 32'd0);
        @(negedge clk);
        checkOutput("redir_req", 32'(imem_req), 32'd1);
        checkOutput("redir_addr", imem_addr, 32'h0000_0100);
        @(negedge clk);
        checkOutput("redir_valid", 32'(inst_valid), 32'd1);
        checkOutput("redir_pc", inst_pc, 32'h0000_0100);
        checkOutput("redir_inst", inst, mem_word(32'h0000_0100));

        // Redirect mid-request; the old transaction drains three cycles later.
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        mem_hold = 1'b1;
        waitReq("drain_req_seen");
        applyStimulus(1'b1, 32'h0000_0200, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("drain_req", 32'(imem_req), 32'd1);
            checkOutput("drain_addr", imem_addr, RESET_PC);
            checkOutput("drain_no_stale", 32'(inst_valid), 32'd0);
            if (k == 3) mem_hold = 1'b0;
        end
        @(negedge clk);
        checkOutput("drain_idle", 32'(imem_req), 32'd0);
        checkOutput("drain_discard", 32'(inst_valid), 32'd0);
        @(negedge clk);
        checkOutput("drain_new_req", 32'(imem_req), 32'd1);
        checkOutput("drain_new_addr", imem_addr, 32'h0000_0200);
        checkOutput("drain_still_empty", 32'(inst_valid), 32'd0);
        @(negedge clk);
        checkOutput("drain_valid", 32'(inst_valid), 32'd1);
        checkOutput("drain_pc", inst_pc, 32'h0000_0200);
        checkOutput("drain_inst", inst, mem_word(32'h0000_0200));

        // Redirect landing in the same cycle as the ack.
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        mem_hold = 1'b1;
        waitReq("coinc_req_seen");
        mem_hold = 1'b0;
        applyStimulus(1'b1, 32'h0000_0300, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("coinc_dropped", 32'(inst_valid), 32'd0);
        checkOutput("coinc_idle", 32'(imem_req), 32'd0);
        @(negedge clk);
        checkOutput("coinc_req", 32'(imem_req), 32'd1);
        checkOutput("coinc_addr", imem_addr, 32'h0000_0300);
        @(negedge clk);
        checkOutput("coinc_valid", 32'(inst_valid), 32'd1);
        checkOutput("coinc_pc", inst_pc, 32'h0000_0300);

        // Vector table: fill with ready low, then drain against a stalled memory.
        doReset();
        lat_max = 0;
        foreach (vecs[v]) begin
            mem_hold = 1'b0;
            applyStimulus(1'b1, vecs[v].start_pc, 1'b0);
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 1'b0);
            repeat (20) @(negedge clk);
            checkOutput("tbl_full_noreq", 32'(imem_req), 32'd0);
            checkOutput("tbl_full_valid", 32'(inst_valid), 32'd1);
            mem_hold = 1'b1;
            applyStimulus(1'b0, 32'h0, 1'b1);
            for (int i = 0; i < DEPTH; i++) begin
                checkOutput("tbl_valid", 32'(inst_valid), 32'd1);
                checkOutput("tbl_pc", inst_pc, vecs[v].exp_pc[i]);
                checkOutput("tbl_inst", inst, mem_word(vecs[v].exp_pc[i]));
                @(negedge clk);
            end
            checkOutput("tbl_empty", 32'(inst_valid), 32'd0);
            checkOutput("tbl_resume_req", 32'(imem_req), 32'd1);
            checkOutput("tbl_resume_addr", imem_addr, vecs[v].exp_next);
        end
        mem_hold = 1'b0;

        // Randomized run against the queue model.
        doReset();
        lat_max = 3;
        q.delete();
        m_busy  = 1'b0;
        m_stale = 1'b0;
        m_addr  = RESET_PC;
        m_npc   = RESET_PC;
        r_prev  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            checkOutput("rnd_req", 32'(imem_req), 32'(m_busy));
            if (m_busy) checkOutput("rnd_addr", imem_addr, m_addr);
            checkOutput("rnd_valid", 32'(inst_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                checkOutput("rnd_pc", inst_pc, q[0].pc);
                checkOutput("rnd_inst", inst, q[0].data);
            end
            r = !r_prev && ($urandom_range(15, 0) == 0);
            r_prev = r;
            applyStimulus(r, $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(1, 0)));
            #2;
            sz0 = q.size();
            if (redirect) begin
                q.delete();
                m_npc = redirect_pc;
                if (m_busy) begin
                    if (imem_ack) begin
                        m_busy  = 1'b0;
                        m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end
            end else begin
                if (sz0 != 0 && inst_ready) void'(q.pop_front());
                if (m_busy) begin
                    if (imem_ack) begin
                        if (m_stale) begin
                            m_busy  = 1'b0;
                            m_stale = 1'b0;
                        end else begin
                            e.pc   = m_addr;
                            e.data = mem_word(m_addr);
                            q.push_back(e);
                            m_npc = m_npc + 32'd4;
`ifdef FETCH_BACK2BACK_EN
                            if (q.size() < DEPTH) m_addr = m_npc;
                            else m_busy = 1'b0;
`else
                            m_busy = 1'b0;
`endif
                        end
                    end
                end else if (sz0 < DEPTH) begin
                    m_busy = 1'b1;
                    m_addr = m_npc;
                end
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
